// File: rtl/poly_arith_pkg.sv
// Shared types and constants for the ML-KEM polynomial arithmetic datapath:
// coefficient type, modulus, Montgomery constant and the NTT twiddle table.
package poly_arith_pkg;

    typedef logic signed [15:0] coeff_t;
    typedef logic signed [31:0] wide_t;

    localparam int Q         = 3329;
    localparam int Q_INV_NEG = 3327;   // -Q^-1 mod 2^16

    // Montgomery-form twiddles in bit-reversed order, centred representatives
    localparam int ZETAS [128] = '{
        -1044,  -758,  -359, -1517,  1493,  1422,   287,   202,
         -171,   622,  1577,   182,   962, -1202, -1474,  1468,
          573, -1325,   264,   383,  -829,  1458, -1602,  -130,
         -681,  1017,   732,   608, -1542,   411,  -205, -1571,
         1223,   652,  -552,  1015, -1293,  1491,  -282, -1544,
          516,    -8,  -320,  -666, -1618, -1162,   126,  1469,
         -853,   -90,  -271,   830,   107, -1421,  -247,  -951,
         -398,   961, -1508,  -725,   448, -1065,   677, -1275,
        -1103,   430,   555,   843, -1251,   871,  1550,   105,
          422,   587,   177,  -235,  -291,  -460,  1574,  1653,
         -246,   778,  1159,  -147,  -777,  1483,  -602,  1119,
        -1590,   644,  -872,   349,   418,   329,  -156,   -75,
          817,  1097,   603,   610,  1322, -1285, -1465,   384,
        -1215,  -136,  1218, -1335,  -874,   220, -1187, -1659,
        -1185, -1530, -1278,   794, -1510,  -854,  -870,   478,
         -108,  -308,   996,   991,   958, -1460,  1522,  1628
    };

    // Twiddle for pair index i: pairs 2k and 2k+1 share ZETAS[64+k] with opposite sign
    function automatic coeff_t zeta_of(input logic [6:0] idx);
        int z;
        z = ZETAS[64 + int'(idx[6:1])];
        return idx[0] ? coeff_t'(-z) : coeff_t'(z);
    endfunction

endpackage

// File: rtl/mont_reduce.sv
// Combinational Montgomery reduction: r = z * 2^-16 mod Q, result in (-Q, Q).
// All intermediate arithmetic wraps at 32 bits to match the software model.
module mont_reduce
    import poly_arith_pkg::*;
(
    input  wide_t  z,
    output coeff_t r
);

    coeff_t m;

    // m is chosen so that z + m*Q has sixteen zero low bits
    assign m = coeff_t'(z * wide_t'(Q_INV_NEG));
    assign r = coeff_t'((z + wide_t'(m) * wide_t'(Q)) >>> 16);

endmodule

// File: rtl/poly_basemul_stream.sv
// Streaming NTT-domain pointwise multiplier (ML-KEM basemul) with internal
// zeta sequencing, 3-stage pipeline and a global valid/ready stall.
// Optional macro POLY_BASEMUL_ACC_EN adds acc0/acc1 inputs that are added
// (16-bit wrap, no reduction) to the results in the last stage.
module poly_basemul_stream
    import poly_arith_pkg::*;
#(
    parameter int NUM_PAIRS = 128,
    parameter int IDX_W     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  coeff_t           a0,
    input  coeff_t           a1,
    input  coeff_t           b0,
    input  coeff_t           b1,
`ifdef POLY_BASEMUL_ACC_EN
    input  coeff_t           acc0,
    input  coeff_t           acc1,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output coeff_t           c0,
    output coeff_t           c1,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last
);

    logic             en;
    logic             accept;
    logic [IDX_W-1:0] cnt_reg, cnt_next, idx_used;
    coeff_t           zeta_next;

    logic             s1_valid_reg, s2_valid_reg, out_valid_reg;
    wide_t            s1_p00_reg, s1_p11_reg, s1_p01_reg, s1_p10_reg;
    coeff_t           s1_zeta_reg, s2_zeta_reg;
    logic [IDX_W-1:0] s1_idx_reg, s2_idx_reg, idx_reg;
    wide_t            s2_p00_reg;
    coeff_t           s2_t_reg, s2_c1_reg;
    coeff_t           c0_reg, c1_reg;

    wide_t            s2_mont_in  [2];
    coeff_t           s2_mont_out [2];
    wide_t            s3_mont_in;
    coeff_t           s3_c0;
    coeff_t           c0_next, c1_next;

    // One enable for every stage: the pipe only moves when the output slot frees up
    assign en       = !out_valid_reg || out_ready;
    assign accept   = in_valid && en;
    assign in_ready = rst || en;

    // Pair index for the incoming beat and the counter value after it
    always_comb begin
        idx_used  = in_first ? '0 : cnt_reg;
        cnt_next  = cnt_reg;
        if (accept) begin
            cnt_next = (idx_used == IDX_W'(NUM_PAIRS - 1)) ? '0 : idx_used + IDX_W'(1);
        end
        zeta_next = zeta_of(7'(idx_used));
    end

    // S2 reductions: t = mont(a1*b1) and c1 = mont(a0*b1 + a1*b0)
    assign s2_mont_in[0] = s1_p11_reg;
    assign s2_mont_in[1] = s1_p01_reg + s1_p10_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_s2_mont
            mont_reduce u_mont (
                .z (s2_mont_in[gi]),
                .r (s2_mont_out[gi])
            );
        end
    endgenerate

    // S3 reduction: c0 = mont(a0*b0 + t*zeta)
    assign s3_mont_in = s2_p00_reg + wide_t'(s2_t_reg) * wide_t'(s2_zeta_reg);

    mont_reduce u_mont_s3 (
        .z (s3_mont_in),
        .r (s3_c0)
    );

`ifdef POLY_BASEMUL_ACC_EN
    coeff_t s1_acc0_reg, s1_acc1_reg, s2_acc0_reg, s2_acc1_reg;

    // Accumulator operands travel alongside their beat
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_acc0_reg <= '0;
            s1_acc1_reg <= '0;
            s2_acc0_reg <= '0;
            s2_acc1_reg <= '0;
        end else if (en) begin
            s1_acc0_reg <= acc0;
            s1_acc1_reg <= acc1;
            s2_acc0_reg <= s1_acc0_reg;
            s2_acc1_reg <= s1_acc1_reg;
        end
    end

    assign c0_next = s3_c0 + s2_acc0_reg;
    assign c1_next = s2_c1_reg + s2_acc1_reg;
`else
    assign c0_next = s3_c0;
    assign c1_next = s2_c1_reg;
`endif

    // Index counter and all pipeline stages; reset drops every in-flight beat
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg       <= '0;
            s1_valid_reg  <= 1'b0;
            s1_p00_reg    <= '0;
            s1_p11_reg    <= '0;
            s1_p01_reg    <= '0;
            s1_p10_reg    <= '0;
            s1_zeta_reg   <= '0;
            s1_idx_reg    <= '0;
            s2_valid_reg  <= 1'b0;
            s2_p00_reg    <= '0;
            s2_t_reg      <= '0;
            s2_c1_reg     <= '0;
            s2_zeta_reg   <= '0;
            s2_idx_reg    <= '0;
            out_valid_reg <= 1'b0;
            c0_reg        <= '0;
            c1_reg        <= '0;
            idx_reg       <= '0;
        end else begin
            cnt_reg <= cnt_next;
            if (en) begin
                s1_valid_reg  <= in_valid;
                s1_p00_reg    <= wide_t'(a0) * wide_t'(b0);
                s1_p11_reg    <= wide_t'(a1) * wide_t'(b1);
                s1_p01_reg    <= wide_t'(a0) * wide_t'(b1);
                s1_p10_reg    <= wide_t'(a1) * wide_t'(b0);
                s1_zeta_reg   <= zeta_next;
                s1_idx_reg    <= idx_used;

                s2_valid_reg  <= s1_valid_reg;
                s2_p00_reg    <= s1_p00_reg;
                s2_t_reg      <= s2_mont_out[0];
                s2_c1_reg     <= s2_mont_out[1];
                s2_zeta_reg   <= s1_zeta_reg;
                s2_idx_reg    <= s1_idx_reg;

                out_valid_reg <= s2_valid_reg;
                c0_reg        <= c0_next;
                c1_reg        <= c1_next;
                idx_reg       <= s2_idx_reg;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign c0        = c0_reg;
    assign c1        = c1_reg;
    assign out_idx   = idx_reg;
    assign out_last  = (idx_reg == IDX_W'(NUM_PAIRS - 1));

endmodule

// File: tb/tb_poly_basemul_stream.sv
// Self-checking bench for poly_basemul_stream: hand-computed vector table,
// directed stall/reset/index sequences and a random stream against a golden model.
module tb_poly_basemul_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               in_valid, in_ready, in_first;
    logic signed [15:0] a0, a1, b0, b1;
    logic               out_valid, out_ready, out_last;
    logic signed [15:0] c0, c1;
    logic [6:0]         out_idx;
`ifdef POLY_BASEMUL_ACC_EN
    logic signed [15:0] acc0, acc1;
`endif

    poly_basemul_stream dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .a0        (a0),
        .a1        (a1),
        .b0        (b0),
        .b1        (b1),
`ifdef POLY_BASEMUL_ACC_EN
        .acc0      (acc0),
        .acc1      (acc1),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c0        (c0),
        .c1        (c1),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    typedef struct {
        int first;
        int a0, a1, b0, b1;
        int c0, c1;
        int idx;
    } vec_t;

    typedef struct {
        int c0, c1, idx;
    } exp_t;

    // ZETAS[64..127], the only part of the table basemul uses
    localparam int ZT [64] = '{
        -1103,   430,   555,   843, -1251,   871,  1550,   105,
          422,   587,   177,  -235,  -291,  -460,  1574,  1653,
         -246,   778,  1159,  -147,  -777,  1483,  -602,  1119,
        -1590,   644,  -872,   349,   418,   329,  -156,   -75,
          817,  1097,   603,   610,  1322, -1285, -1465,   384,
        -1215,  -136,  1218, -1335,  -874,   220, -1187, -1659,
        -1185, -1530, -1278,   794, -1510,  -854,  -870,   478,
         -108,  -308,   996,   991,   958, -1460,  1522,  1628
    };

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    bit   rand_ready = 1'b0;
    vec_t tbl [13];

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    function automatic int mont(input int z);
        int m;
        m = int'(shortint'(z * 3327));
        return int'(shortint'((z + m * 3329) >>> 16));
    endfunction

    function automatic int zeta_model(input int idx);
        return (idx % 2 == 1) ? -ZT[idx / 2] : ZT[idx / 2];
    endfunction

    task automatic golden(input int xa0, xa1, xb0, xb1, idx, output int ec0, ec1);
        int t;
        t   = mont(xa1 * xb1);
        ec1 = mont(xa0 * xb1 + xa1 * xb0);
        ec0 = mont(xa0 * xb0 + t * zeta_model(idx));
    endtask

    // Offer one beat at a negedge, wait (bounded) for in_ready, record expectation
    task automatic send(input int first, xa0, xa1, xb0, xb1, xacc0, xacc1,
                        input int ec0, ec1, eidx);
        exp_t e;
        int   waited;
        @(negedge clk);
        in_valid = 1'b1;
        in_first = (first != 0);
        a0 = 16'(xa0);
        a1 = 16'(xa1);
        b0 = 16'(xb0);
        b1 = 16'(xb1);
`ifdef POLY_BASEMUL_ACC_EN
        acc0 = 16'(xacc0);
        acc1 = 16'(xacc1);
`else
        if (xacc0 != 0 || xacc1 != 0) $display("note: acc ignored in this build");
`endif
        waited = 0;
        #1;
        while (!in_ready && waited < 1000) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", int'(in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        e.c0  = ec0;
        e.c1  = ec1;
        e.idx = eidx;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Output monitor: every accepted output beat is matched in order against the queue
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (!rst && out_valid && out_ready) begin
            $display("out idx=%0d c0=%0d c1=%0d last=%0d", out_idx, c0, c1, out_last);
            if (exp_q.size() == 0) begin
                check("unexpected_out", int'(out_valid), 0);
            end else begin
                e = exp_q.pop_front();
                check("c0", int'(c0), e.c0);
                check("c1", int'(c1), e.c1);
                check("out_idx", int'(out_idx), e.idx);
                check("out_last", int'(out_last), (e.idx == 127) ? 1 : 0);
            end
        end
    end

    // Random backpressure during the random phase
    always @(negedge clk) begin
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rnd_cnt, idx, first, xa0, xa1, xb0, xb1, ec0, ec1;

        // first, a0, a1, b0, b1, c0, c1, idx
        tbl[0]  = '{1,      1, 0,      1, 0,   169,     0, 0};
        tbl[1]  = '{0,      1, 0,      0, 1,     0,   169, 1};
        tbl[2]  = '{0,      2, 0,      3, 0,  1014,     0, 2};
        tbl[3]  = '{0,      3, 0,      4, 2, -1301,  1014, 3};
        tbl[4]  = '{0,     -1, 0,      1, 0,  -169,     0, 4};
        tbl[5]  = '{0,   3328, 0,   3328, 0,   169,     0, 5};
        tbl[6]  = '{0,   3328, 0,  -3328, 0,  -169,     0, 6};
        tbl[7]  = '{1,      0, 1,      0, 1,  -456,     0, 0};
        tbl[8]  = '{0,      0, 1,      0, 1,   456,     0, 1};
        tbl[9]  = '{0,      0, 1,      0, 1,   549,     0, 2};
        tbl[10] = '{0,      0, 1,      0, 1,  -549,     0, 3};
        tbl[11] = '{0,      0, 4,     -2, 0,     0, -1352, 4};
        tbl[12] = '{0, -32768, 0, -32768, 0, 16384,     0, 5};

        rst = 1'b1;
        in_valid = 1'b0;
        in_first = 1'b0;
        a0 = '0; a1 = '0; b0 = '0; b1 = '0;
`ifdef POLY_BASEMUL_ACC_EN
        acc0 = '0; acc1 = '0;
`endif
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("in_ready_during_rst", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_c0", int'(c0), 0);
        check("rst_c1", int'(c1), 0);
        check("rst_out_idx", int'(out_idx), 0);
        check("rst_out_last", int'(out_last), 0);

        // First beat after reset: latency of exactly three cycles
        send(1, 1, 0, 1, 0, 0, 0, 169, 0, 0);
        idle();
        #1;
        check("lat_cycle1", int'(out_valid), 0);
        @(negedge clk);
        #1;
        check("lat_cycle2", int'(out_valid), 0);
        @(negedge clk);
        #1;
        check("lat_cycle3", int'(out_valid), 1);
        drain();

        // Hand-computed vector table, back to back
        for (int i = 0; i < 13; i++) begin
            send(tbl[i].first, tbl[i].a0, tbl[i].a1, tbl[i].b0, tbl[i].b1, 0, 0,
                 tbl[i].c0, tbl[i].c1, tbl[i].idx);
        end
        idle();
        drain();

        // 130 zero beats: index wraps 127 -> 0 without a gap
        for (int i = 0; i < 130; i++) begin
            send((i == 0) ? 1 : 0, 0, 0, 0, 0, 0, 0, 0, 0, i % 128);
        end
        idle();
        drain();

        // in_first mid-stream at beat 40 restarts the index and the zeta
        for (int i = 0; i < 40; i++) begin
            send((i == 0) ? 1 : 0, 0, 0, 0, 0, 0, 0, 0, 0, i);
        end
        send(1, 0, 1, 0, 1, 0, 0, -456, 0, 0);
        send(0, 0, 1, 0, 1, 0, 0, 456, 0, 1);
        idle();
        drain();

        // Full pipe with out_ready low: hold for five cycles, then release
        idle();
        out_ready = 1'b0;
        send(1, 2, 0, 3, 0, 0, 0, 1014, 0, 0);
        send(0, 3, 0, 4, 2, 0, 0, -1301, 1014, 1);
        send(0, -1, 0, 1, 0, 0, 0, -169, 0, 2);
        fork
            send(0, 1, 0, 1, 0, 0, 0, 169, 0, 3);
            begin
                repeat (5) begin
                    @(negedge clk);
                    #1;
                    check("stall_in_ready", int'(in_ready), 0);
                    check("stall_out_valid", int'(out_valid), 1);
                    check("stall_c0", int'(c0), exp_q[0].c0);
                    check("stall_c1", int'(c1), exp_q[0].c1);
                    check("stall_out_idx", int'(out_idx), exp_q[0].idx);
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        idle();
        drain();

        // Reset with three beats in flight: they vanish and the index restarts
        idle();
        out_ready = 1'b0;
        send(1, 2, 0, 3, 0, 0, 0, 1014, 0, 0);
        send(0, 2, 0, 3, 0, 0, 0, 1014, 0, 1);
        send(0, 2, 0, 3, 0, 0, 0, 1014, 0, 2);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("in_ready_in_rst", int'(in_ready), 1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_rst_out_valid", int'(out_valid), 0);
        send(0, 1, 0, 1, 0, 0, 0, 169, 0, 0);
        idle();
        drain();

`ifdef POLY_BASEMUL_ACC_EN
        // Accumulate inputs added after reduction
        send(1, 1, 0, 1, 0, 5, -2, 174, -2, 0);
        idle();
        drain();
`endif

        // Random stream with input gaps and output backpressure
        rand_ready = 1'b1;
        rnd_cnt = 0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            xa0 = int'($urandom_range(0, 6656)) - 3328;
            xa1 = int'($urandom_range(0, 6656)) - 3328;
            xb0 = int'($urandom_range(0, 6656)) - 3328;
            xb1 = int'($urandom_range(0, 6656)) - 3328;
            first = (i == 0 || $urandom_range(0, 255) == 0) ? 1 : 0;
            idx = (first != 0) ? 0 : rnd_cnt;
            rnd_cnt = (idx == 127) ? 0 : idx + 1;
            golden(xa0, xa1, xb0, xb1, idx, ec0, ec1);
            send(first, xa0, xa1, xb0, xb1, 0, 0, ec0, ec1, idx);
        end
        idle();
        rand_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
